// File: rtl/hex_display_scan.sv
// Time-multiplexed scan driver for common-anode seven-segment digits.
// Captures a hex value on load, then enables one digit per slot with optional leading-zero blanking.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_DARK | display off: all anodes high, blank asserted, no scanning
// ST_SCAN | cycling digit index every PRESCALE clocks from hold register
module hex_display_scan #(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 50000,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [4*DIGITS-1:0]   data_in,
   input  logic                  load,
   input  logic                  clear,
   output logic [3:0]            nibble,
   output logic                  blank,
   output logic [DIGITS-1:0]     digit_en,
   output logic                  loaded
);

   localparam int IW = $clog2(DIGITS);
   localparam int CW = $clog2(PRESCALE);

   typedef enum logic {ST_DARK, ST_SCAN} state_t;

   state_t                state;
   logic [4*DIGITS-1:0]   hold;
   logic [CW-1:0]         slot_tmr;
   logic [IW-1:0]         idx;
   logic                  load_acc;
   logic [DIGITS-1:0]     lz_blank;
   logic                  upper_zero;
   logic [3:0]            cur_nib;

   // A digit is blanked when it and every digit above it is zero; digit 0 always shows.
   always_comb begin
      lz_blank   = '0;
      upper_zero = 1'b1;
      for (int i = DIGITS-1; i >= 1; i--) begin
         upper_zero  = upper_zero & (hold[4*i +: 4] == 4'h0);
         lz_blank[i] = BLANK_LZ & upper_zero;
      end
   end

   assign cur_nib = hold[{idx, 2'b00} +: 4];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= ST_DARK;
         hold     <= '0;
         slot_tmr <= CW'(PRESCALE-1);
         idx      <= '0;
         load_acc <= 1'b0;
         loaded   <= 1'b0;
         digit_en <= '1;
         nibble   <= 4'h0;
         blank    <= 1'b1;
      end else begin
         // Acknowledge lands together with the first output change of the new value.
         load_acc <= load & ~clear;
         loaded   <= load_acc;

         if (state == ST_SCAN) begin
            digit_en <= ~(DIGITS'(1) << idx);
            nibble   <= lz_blank[idx] ? 4'h0 : cur_nib;
            blank    <= lz_blank[idx];
         end else begin
            digit_en <= '1;
            nibble   <= 4'h0;
            blank    <= 1'b1;
         end

         if (clear) begin
            state    <= ST_DARK;
            hold     <= '0;
            slot_tmr <= CW'(PRESCALE-1);
            idx      <= '0;
         end else if (state == ST_DARK) begin
            if (load) begin
               state    <= ST_SCAN;
               hold     <= data_in;
               slot_tmr <= CW'(PRESCALE-1);
               idx      <= '0;
            end
         end else begin
            if (load)
               hold <= data_in;
            if (slot_tmr == '0) begin
               slot_tmr <= CW'(PRESCALE-1);
               idx      <= (idx == IW'(DIGITS-1)) ? '0 : idx + IW'(1);
            end else begin
               slot_tmr <= slot_tmr - CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_hex_display_scan.sv
// Directed bench for hex_display_scan: table of per-cycle vectors plus reset sequences.
// A second instance with leading-zero blanking disabled shares all stimulus.
module tb_hex_display_scan;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic [15:0] data_in = 16'h0;
   logic        load = 1'b0;
   logic        clear = 1'b0;
   logic [3:0]  nibble, nibble_nb;
   logic        blank, blank_nb;
   logic [3:0]  digit_en, digit_en_nb;
   logic        loaded, loaded_nb;

   int vectors = 0;
   int miscompares = 0;
   int vec_no = 0;

   localparam logic [15:0] IDLE = 16'hDEAD;

   hex_display_scan #(.DIGITS(4), .PRESCALE(4), .BLANK_LZ(1'b1)) dut (
      .clk(clk), .resetn(resetn), .data_in(data_in), .load(load), .clear(clear),
      .nibble(nibble), .blank(blank), .digit_en(digit_en), .loaded(loaded));

   hex_display_scan #(.DIGITS(4), .PRESCALE(4), .BLANK_LZ(1'b0)) dut_nb (
      .clk(clk), .resetn(resetn), .data_in(data_in), .load(load), .clear(clear),
      .nibble(nibble_nb), .blank(blank_nb), .digit_en(digit_en_nb), .loaded(loaded_nb));

   always #5 clk = ~clk;

   typedef struct {
      logic        ld;
      logic        clr;
      logic [15:0] data;
      logic [3:0]  en;
      logic [3:0]  nib;
      logic        blk;
      logic        blk_nb;
      logic        lded;
   } vec_t;

   vec_t tbl[$];

   function automatic void push(logic ld, logic clr, logic [15:0] data, logic [3:0] en,
                                logic [3:0] nib, logic blk, logic blk_nb, logic lded);
      vec_t v;
      v.ld = ld; v.clr = clr; v.data = data; v.en = en;
      v.nib = nib; v.blk = blk; v.blk_nb = blk_nb; v.lded = lded;
      tbl.push_back(v);
   endfunction

   function automatic void slot(int n, logic [3:0] en, logic [3:0] nib, logic blk, logic blk_nb);
      for (int i = 0; i < n; i++)
         push(1'b0, 1'b0, IDLE, en, nib, blk, blk_nb, 1'b0);
   endfunction

   task automatic chk(string nm, logic [3:0] act, logic [3:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s (vector %0d): got %h expected %h", nm, vec_no, act, exp);
      end
   endtask

   task automatic chk_all(logic [3:0] en, logic [3:0] nib, logic blk, logic blk_nb, logic lded);
      vectors++;
      chk("digit_en", digit_en, en);
      chk("nibble", nibble, nib);
      chk("blank", {3'b0, blank}, {3'b0, blk});
      chk("loaded", {3'b0, loaded}, {3'b0, lded});
      chk("digit_en_nb", digit_en_nb, en);
      chk("nibble_nb", nibble_nb, nib);
      chk("blank_nb", {3'b0, blank_nb}, {3'b0, blk_nb});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // 1A3F from dark, then clear
      push(1'b1, 1'b0, 16'h1A3F, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0);
      push(1'b0, 1'b0, IDLE,     4'hE, 4'hF, 1'b0, 1'b0, 1'b1);
      slot(3, 4'hE, 4'hF, 1'b0, 1'b0);
      slot(4, 4'hD, 4'h3, 1'b0, 1'b0);
      slot(4, 4'hB, 4'hA, 1'b0, 1'b0);
      slot(4, 4'h7, 4'h1, 1'b0, 1'b0);
      slot(1, 4'hE, 4'hF, 1'b0, 1'b0);
      push(1'b0, 1'b1, IDLE,     4'hE, 4'hF, 1'b0, 1'b0, 1'b0);
      slot(1, 4'hF, 4'h0, 1'b1, 1'b1);
      // 0050: upper two digits blanked
      push(1'b1, 1'b0, 16'h0050, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0);
      push(1'b0, 1'b0, IDLE,     4'hE, 4'h0, 1'b0, 1'b0, 1'b1);
      slot(3, 4'hE, 4'h0, 1'b0, 1'b0);
      slot(4, 4'hD, 4'h5, 1'b0, 1'b0);
      slot(4, 4'hB, 4'h0, 1'b1, 1'b0);
      slot(4, 4'h7, 4'h0, 1'b1, 1'b0);
      slot(1, 4'hE, 4'h0, 1'b0, 1'b0);
      // 0000 loaded mid-scan: only digit 0 shown
      push(1'b1, 1'b0, 16'h0000, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0);
      push(1'b0, 1'b0, IDLE,     4'hE, 4'h0, 1'b0, 1'b0, 1'b1);
      slot(1, 4'hE, 4'h0, 1'b0, 1'b0);
      slot(4, 4'hD, 4'h0, 1'b1, 1'b0);
      slot(4, 4'hB, 4'h0, 1'b1, 1'b0);
      slot(4, 4'h7, 4'h0, 1'b1, 1'b0);
      slot(4, 4'hE, 4'h0, 1'b0, 1'b0);
      slot(4, 4'hD, 4'h0, 1'b1, 1'b0);
      slot(1, 4'hB, 4'h0, 1'b1, 1'b0);
      // BEEF while digit 2 enabled: no index restart
      push(1'b1, 1'b0, 16'hBEEF, 4'hB, 4'h0, 1'b1, 1'b0, 1'b0);
      push(1'b0, 1'b0, IDLE,     4'hB, 4'hE, 1'b0, 1'b0, 1'b1);
      slot(1, 4'hB, 4'hE, 1'b0, 1'b0);
      slot(1, 4'h7, 4'hB, 1'b0, 1'b0);
      // load+clear together, then reload and back-to-back loads
      push(1'b1, 1'b1, 16'h1234, 4'h7, 4'hB, 1'b0, 1'b0, 1'b0);
      slot(2, 4'hF, 4'h0, 1'b1, 1'b1);
      push(1'b1, 1'b0, 16'h1234, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0);
      push(1'b0, 1'b0, IDLE,     4'hE, 4'h4, 1'b0, 1'b0, 1'b1);
      push(1'b1, 1'b0, 16'h5678, 4'hE, 4'h4, 1'b0, 1'b0, 1'b0);
      push(1'b1, 1'b0, 16'h9ABC, 4'hE, 4'h8, 1'b0, 1'b0, 1'b1);
      push(1'b0, 1'b0, IDLE,     4'hE, 4'hC, 1'b0, 1'b0, 1'b1);
      push(1'b0, 1'b0, IDLE,     4'hD, 4'hB, 1'b0, 1'b0, 1'b0);

      // asynchronous reset assertion, no clock edge needed
      #1 resetn = 1'b0;
      #1 chk_all(4'hF, 4'h0, 1'b1, 1'b1, 1'b0);
      step();
      resetn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         data_in = 16'(i * 16'h1111);
         step();
         vec_no = i;
         chk_all(4'hF, 4'h0, 1'b1, 1'b1, 1'b0);
      end

      for (int i = 0; i < tbl.size(); i++) begin
         load    = tbl[i].ld;
         clear   = tbl[i].clr;
         data_in = tbl[i].data;
         step();
         vec_no = 100 + i;
         chk_all(tbl[i].en, tbl[i].nib, tbl[i].blk, tbl[i].blk_nb, tbl[i].lded);
      end
      load = 1'b0;
      clear = 1'b0;

      // reset pulled low between edges while scanning
      @(posedge clk);
      #3 resetn = 1'b0;
      #1 vec_no = 200;
      chk_all(4'hF, 4'h0, 1'b1, 1'b1, 1'b0);
      step();
      resetn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         vec_no = 201 + i;
         chk_all(4'hF, 4'h0, 1'b1, 1'b1, 1'b0);
      end
      load = 1'b1;
      data_in = 16'h00AB;
      step();
      vec_no = 210;
      chk_all(4'hF, 4'h0, 1'b1, 1'b1, 1'b0);
      load = 1'b0;
      step();
      vec_no = 211;
      chk_all(4'hE, 4'hB, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step();
      vec_no = 212;
      chk_all(4'hD, 4'hA, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
